// File: rtl/ddr2_host_master.sv
`timescale 1ns/1ps
// Host-side initiator for the DDR2 server controller: turns one write/read burst request
// into the put_dataFIFO / cmd_put / FETCHING sequence and returns read beats via a 2-entry skid.
//
// state        | meaning
// S_IDLE       | ready for a new request
// S_WAIT_RDY   | request latched, waiting for controller READY
// S_WR_DATA    | streaming write beats into the controller data FIFO
// S_WR_CMD     | one-cycle write command enqueue
// S_RD_CMD     | one-cycle read command enqueue
// S_RD_COLLECT | draining VALIDOUT beats into the skid buffer
module ddr2_host_master #(
  parameter int         HOST_ADDR_WIDTH = 25,
  parameter logic [2:0] CMD_READ        = 3'b001,
  parameter logic [2:0] CMD_WRITE       = 3'b010,
  parameter int         TIMEOUT_CYCLES  = 4096
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [1:0]                 req_sz,
  input  logic [HOST_ADDR_WIDTH-1:0] req_addr,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [63:0]                wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [63:0]                rd_data,
  output logic [HOST_ADDR_WIDTH-1:0] rd_addr,
  output logic                       busy,
  output logic                       err_timeout,
  output logic                       err_overflow,
  output logic [2:0]                 CMD,
  output logic [1:0]                 SZ,
  output logic [HOST_ADDR_WIDTH-1:0] ADDR,
  output logic                       cmd_put,
  output logic [63:0]                DIN,
  output logic                       put_dataFIFO,
  output logic                       FETCHING,
  input  logic [63:0]                DOUT,
  input  logic [HOST_ADDR_WIDTH-1:0] RADDR,
  input  logic                       VALIDOUT,
  input  logic                       READY,
  input  logic                       NOTFULL
);

  localparam int SW = 64 + HOST_ADDR_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WR_DATA, S_WR_CMD, S_RD_CMD, S_RD_COLLECT
  } state_t;

  state_t                      state_q, state_d, state_nat;
  logic                        write_q, write_d;
  logic [1:0]                  sz_q, sz_d;
  logic [HOST_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [5:0]                  beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        err_tmo_q, err_tmo_d;
  logic                        err_ovf_q, err_ovf_d;
  logic                        req_ready_q, req_ready_d;
  logic [1:0]                  occ_q, occ_d;
  logic                        wp_q, wp_d, rp_q, rp_d;
  logic [1:0][SW-1:0]          skid_q, skid_d;

  logic in_collect, pop, push, vo_take, wr_acc, ovf_evt, progress;
  logic [SW-1:0] head;

  assign in_collect = (state_q == S_RD_COLLECT);
  assign pop        = (occ_q != 2'd0) && rd_ready;
  assign wr_acc     = (state_q == S_WR_DATA) && NOTFULL && wr_valid;
  assign vo_take    = in_collect && VALIDOUT && (beat_cnt_q != 6'd0);
  assign push       = vo_take && ((occ_q != 2'd2) || pop);
  // A beat that cannot be stored, or arrives when none is owed, is dropped and flagged.
  assign ovf_evt    = VALIDOUT && (!in_collect || (beat_cnt_q == 6'd0) ||
                                   ((occ_q == 2'd2) && !pop));

  always_comb begin
    state_nat  = state_q;
    write_d    = write_q;
    sz_d       = sz_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    tmo_d      = tmo_q;
    err_tmo_d  = err_tmo_q;
    err_ovf_d  = err_ovf_q | ovf_evt;
    skid_d     = skid_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    progress   = 1'b0;

    if (push) begin
      skid_d[wp_q] = {DOUT, RADDR};
      wp_d         = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    occ_d = occ_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          write_d    = req_write;
          sz_d       = req_sz;
          addr_d     = req_addr;
          beat_cnt_d = {({1'b0, req_sz} + 3'd1), 3'b000};
          state_nat  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (READY) begin
          progress  = 1'b1;
          state_nat = write_q ? S_WR_DATA : S_RD_CMD;
        end
      end
      S_WR_DATA: begin
        if (wr_acc) begin
          progress   = 1'b1;
          beat_cnt_d = beat_cnt_q - 6'd1;
          if (beat_cnt_q == 6'd1) state_nat = S_WR_CMD;
        end
      end
      S_WR_CMD: state_nat = S_IDLE;
      S_RD_CMD: state_nat = S_RD_COLLECT;
      S_RD_COLLECT: begin
        if (vo_take) beat_cnt_d = beat_cnt_q - 6'd1;
        progress = vo_take || pop;
        if ((beat_cnt_d == 6'd0) && (occ_d == 2'd0)) state_nat = S_IDLE;
      end
      default: state_nat = S_IDLE;
    endcase

    // Watchdog down-counter: reloads on any movement, expiry aborts to IDLE.
    if ((state_q == S_IDLE) || (state_nat != state_q) || progress) begin
      tmo_d = TMO_LOAD;
    end else if (tmo_q == '0) begin
      err_tmo_d = 1'b1;
      state_nat = S_IDLE;
      occ_d     = 2'd0;
      wp_d      = 1'b0;
      rp_d      = 1'b0;
      tmo_d     = TMO_LOAD;
    end else begin
      tmo_d = tmo_q - TW'(1);
    end

    state_d     = state_nat;
    req_ready_d = (state_nat == S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      sz_q        <= '0;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      tmo_q       <= TMO_LOAD;
      err_tmo_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      req_ready_q <= 1'b0;
      occ_q       <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      sz_q        <= sz_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      tmo_q       <= tmo_d;
      err_tmo_q   <= err_tmo_d;
      err_ovf_q   <= err_ovf_d;
      req_ready_q <= req_ready_d;
      occ_q       <= occ_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      skid_q      <= skid_d;
    end
  end

  assign head         = skid_q[rp_q];
  assign req_ready    = req_ready_q;
  assign wr_ready     = (state_q == S_WR_DATA) && NOTFULL;
  assign DIN          = wr_data;
  assign put_dataFIFO = wr_acc;
  assign cmd_put      = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
  assign CMD          = (state_q == S_WR_CMD) ? CMD_WRITE :
                        (state_q == S_RD_CMD) ? CMD_READ  : 3'b000;
  assign SZ           = sz_q;
  assign ADDR         = addr_q;
  assign FETCHING     = in_collect && ((occ_q == 2'd0) || ((occ_q == 2'd1) && rd_ready));
  assign rd_valid     = (occ_q != 2'd0);
  assign {rd_data, rd_addr} = rd_valid ? head : '0;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_tmo_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_ddr2_host_master.sv
`timescale 1ns/1ps
// Scoreboarded bench for ddr2_host_master: a controller model answers commands, stimulus
// pushes expected beats/commands into queues and a monitor pops and compares them.
module tb_ddr2_host_master;
  localparam int HAW = 25;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            req_valid, req_ready, req_write;
  logic [1:0]      req_sz;
  logic [HAW-1:0]  req_addr;
  logic            wr_valid, wr_ready;
  logic [63:0]     wr_data;
  logic            rd_valid, rd_ready;
  logic [63:0]     rd_data;
  logic [HAW-1:0]  rd_addr;
  logic            busy, err_timeout, err_overflow;
  logic [2:0]      CMD;
  logic [1:0]      SZ;
  logic [HAW-1:0]  ADDR;
  logic            cmd_put, put_dataFIFO, FETCHING;
  logic [63:0]     DIN, DOUT;
  logic [HAW-1:0]  RADDR;
  logic            VALIDOUT, READY, NOTFULL;

  ddr2_host_master dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sz(req_sz), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .busy(busy), .err_timeout(err_timeout), .err_overflow(err_overflow),
    .CMD(CMD), .SZ(SZ), .ADDR(ADDR), .cmd_put(cmd_put),
    .DIN(DIN), .put_dataFIFO(put_dataFIFO), .FETCHING(FETCHING),
    .DOUT(DOUT), .RADDR(RADDR), .VALIDOUT(VALIDOUT), .READY(READY), .NOTFULL(NOTFULL)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]     cmd;
    logic [1:0]     sz;
    logic [HAW-1:0] addr;
  } cmd_t;

  int total = 0;
  int bad   = 0;

  logic [63:0]       exp_din[$];
  cmd_t              exp_cmd[$];
  logic [64+HAW-1:0] exp_rd[$];
  logic [63:0]       wbeats[$];

  int             puts_since_cmd = 0;
  int             cmd_seen = 0;
  int             rd_left = 0;
  int             rd_idx = 0;
  int             rd_issued = 0;
  int             rd_pops = 0;
  logic [HAW-1:0] rd_base = '0;
  bit ready_low = 1'b0, nf_low = 1'b0, nf_rand = 1'b0, vo_gap = 1'b0;
  bit rr_rand = 1'b0, rr_val = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // DDR2 controller model: honours FETCHING with zero latency, returns sequential addresses.
  initial begin
    READY = 1'b0; NOTFULL = 1'b0; VALIDOUT = 1'b0; DOUT = '0; RADDR = '0;
    forever begin
      @(negedge CLK); #1;
      READY   = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      NOTFULL = nf_low ? 1'b0 : (nf_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (FETCHING && rd_left > 0 && (!vo_gap || $urandom_range(0, 2) != 0)) begin
        VALIDOUT = 1'b1;
        DOUT     = {$urandom, $urandom};
        RADDR    = rd_base + HAW'(rd_idx);
        exp_rd.push_back({DOUT, RADDR});
        rd_left--; rd_idx++; rd_issued++;
      end else begin
        VALIDOUT = 1'b0; DOUT = '0; RADDR = '0;
      end
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(negedge CLK);
      rd_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    end
  end

  // Monitor: every handshake the DUT presents is matched against the queues.
  initial begin
    cmd_t c;
    forever begin
      @(negedge CLK); #3;
      if (put_dataFIFO) begin
        puts_since_cmd++;
        if (exp_din.size() == 0) begin
          total++; bad++;
          $display("FAIL din_unexpected actual=%0h required=none", DIN);
        end else check("din", 128'(DIN), 128'(exp_din.pop_front()));
      end
      if (cmd_put) begin
        cmd_seen++;
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected actual=%0h required=none", {CMD, SZ, ADDR});
        end else begin
          c = exp_cmd.pop_front();
          check("cmd_fields", 128'({CMD, SZ, ADDR}), 128'(c));
          if (c.cmd == 3'b010) begin
            check("put_count", 128'(puts_since_cmd), 128'(8 * (int'(c.sz) + 1)));
          end else begin
            rd_left = 8 * (int'(c.sz) + 1);
            rd_base = c.addr;
            rd_idx  = 0;
          end
          puts_since_cmd = 0;
        end
      end
      if (rd_valid && rd_ready) begin
        rd_pops++;
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected actual=%0h required=none", {rd_data, rd_addr});
        end else check("rd_beat", 128'({rd_data, rd_addr}), 128'(exp_rd.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic expect_write(input logic [1:0] sz, input logic [HAW-1:0] addr);
    cmd_t c;
    for (int i = 0; i < 8 * (int'(sz) + 1); i++) exp_din.push_back(wbeats[i]);
    c.cmd = 3'b010; c.sz = sz; c.addr = addr;
    exp_cmd.push_back(c);
  endtask

  task automatic expect_read_cmd(input logic [1:0] sz, input logic [HAW-1:0] addr);
    cmd_t c;
    c.cmd = 3'b001; c.sz = sz; c.addr = addr;
    exp_cmd.push_back(c);
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic [HAW-1:0] addr);
    int guard = 0;
    bit done = 1'b0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_sz = sz; req_addr = addr;
    while (!done && guard < 200) begin
      #3;
      if (req_ready) done = 1'b1;
      else begin @(negedge CLK); guard++; end
    end
    check("req_accepted", 128'(done), 128'(1));
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic drive_write(input int n, input bit gap);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge CLK);
      guard++;
      if (gap && $urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0; wr_data = {$urandom, $urandom};
      end else begin
        wr_valid = 1'b1; wr_data = wbeats[i];
        #3;
        if (wr_ready) i++;
      end
    end
    check("write_beats_sent", 128'(i), 128'(n));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge CLK); #3; n++;
    end while (busy && n < budget);
    check(name, 128'(busy), 128'(0));
    @(negedge CLK);
    wr_valid = 1'b0;
  endtask

  initial begin
    logic [1:0]     sz;
    logic [HAW-1:0] addr;
    int             cnt, c0;
    bit             w, stalled;

    RESET = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_sz = '0; req_addr = '0;
    wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge CLK);
    #3;
    check("reset_outputs", {req_ready, wr_ready, rd_valid, busy, err_timeout, err_overflow,
                            cmd_put, put_dataFIFO, FETCHING, CMD, SZ, ADDR, rd_data, rd_addr},
          128'(0));
    @(negedge CLK); RESET = 1'b0;
    @(negedge CLK); #3;
    check("req_ready_idle", 128'(req_ready), 128'(1));

    // Directed write: 8 beats 1..8 to 0x100.
    wbeats.delete();
    for (int i = 1; i <= 8; i++) wbeats.push_back(64'(i));
    expect_write(2'd0, 25'h100);
    do_req(1'b1, 2'd0, 25'h100);
    drive_write(8, 1'b0);
    wait_idle("wr8_idle", 200);
    check("wr8_cmd_count", 128'(cmd_seen), 128'(1));

    // Write sz=1 with NOTFULL held low for three cycles mid-burst.
    wbeats.delete();
    for (int i = 0; i < 16; i++) wbeats.push_back({$urandom, $urandom});
    expect_write(2'd1, 25'h0ABCDE);
    do_req(1'b1, 2'd1, 25'h0ABCDE);
    fork
      drive_write(16, 1'b0);
      begin
        cnt = 0;
        while (puts_since_cmd < 6 && cnt < 200) begin @(negedge CLK); #3; cnt++; end
        stalled = (puts_since_cmd >= 6);
        check("stall_reached", 128'(stalled), 128'(1));
        nf_low = 1'b1;
        repeat (3) begin
          @(negedge CLK); #3;
          check("stall_wr_ready", 128'(wr_ready), 128'(0));
          check("stall_put", 128'(put_dataFIFO), 128'(0));
        end
        nf_low = 1'b0;
      end
    join
    wait_idle("wr16_idle", 200);

    // Directed read: 32 beats from the top address, client always ready.
    rr_rand = 1'b0; rr_val = 1'b1; rd_pops = 0;
    expect_read_cmd(2'd3, 25'h1FFFFFF);
    do_req(1'b0, 2'd3, 25'h1FFFFFF);
    wait_idle("rd32_idle", 400);
    check("rd32_pops", 128'(rd_pops), 128'(32));
    check("rd32_queue_empty", 128'(exp_rd.size()), 128'(0));

    // Read sz=0 with client stalled: FETCHING must close once a beat is held.
    rr_val = 1'b0; rd_pops = 0; rd_issued = 0;
    expect_read_cmd(2'd0, 25'h0000040);
    do_req(1'b0, 2'd0, 25'h0000040);
    repeat (15) @(negedge CLK);
    #3;
    check("hold_fetching", 128'(FETCHING), 128'(0));
    check("hold_rd_valid", 128'(rd_valid), 128'(1));
    check("hold_issued", 128'(rd_issued), 128'(1));
    rr_val = 1'b1;
    wait_idle("hold_idle", 200);
    check("hold_pops", 128'(rd_pops), 128'(8));
    check("hold_no_overflow", 128'(err_overflow), 128'(0));

    // Randomized mixed traffic.
    nf_rand = 1'b1; vo_gap = 1'b1; rr_rand = 1'b1;
    for (int t = 0; t < 14; t++) begin
      w    = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = HAW'($urandom);
      if (w) begin
        wbeats.delete();
        for (int i = 0; i < 8 * (int'(sz) + 1); i++) wbeats.push_back({$urandom, $urandom});
        expect_write(sz, addr);
        do_req(1'b1, sz, addr);
        drive_write(8 * (int'(sz) + 1), 1'b1);
        wait_idle("rand_wr_idle", 1000);
      end else begin
        rd_pops = 0;
        expect_read_cmd(sz, addr);
        do_req(1'b0, sz, addr);
        wait_idle("rand_rd_idle", 1000);
        check("rand_rd_pops", 128'(rd_pops), 128'(8 * (int'(sz) + 1)));
      end
    end
    check("rand_queues_empty", 128'(exp_din.size() + exp_cmd.size() + exp_rd.size()), 128'(0));
    check("rand_errors", 128'({err_timeout, err_overflow}), 128'(0));

    // Timeout: READY never comes.
    nf_rand = 1'b0; vo_gap = 1'b0; rr_rand = 1'b0; rr_val = 1'b1;
    ready_low = 1'b1;
    c0 = cmd_seen;
    do_req(1'b0, 2'd2, 25'h0001234);
    cnt = 0;
    while (!err_timeout && cnt < 6000) begin @(negedge CLK); #3; cnt++; end
    check("tmo_flag", 128'(err_timeout), 128'(1));
    check("tmo_window", 128'(cnt >= 4085 && cnt <= 4100), 128'(1));
    check("tmo_idle", 128'({busy, req_ready}), 128'(2'b01));
    check("tmo_no_cmd", 128'(cmd_seen), 128'(c0));
    ready_low = 1'b0;

    // Reset during the fourth write beat aborts without a command.
    wbeats.delete();
    for (int i = 0; i < 8; i++) wbeats.push_back({$urandom, $urandom});
    expect_write(2'd0, 25'h0000200);
    do_req(1'b1, 2'd0, 25'h0000200);
    drive_write(3, 1'b0);
    @(negedge CLK);
    wr_valid = 1'b1; wr_data = wbeats[3];
    #1 RESET = 1'b1;
    #1;
    check("async_reset_outs", {busy, req_ready, wr_ready, put_dataFIFO, cmd_put, FETCHING,
                               rd_valid, err_timeout, err_overflow}, 128'(0));
    wr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    exp_din.delete(); exp_cmd.delete(); puts_since_cmd = 0;
    c0 = cmd_seen;
    repeat (20) @(negedge CLK);
    #3;
    check("abort_no_cmd", 128'(cmd_seen), 128'(c0));
    check("abort_idle", 128'({busy, req_ready, err_timeout}), 128'(3'b010));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
